// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/grant/response channel
// and the IF/ID valid/ready hand-off toward decode.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        id_ready;

  modport master (
    output imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr,
    input  imem_gnt, imem_rvalid, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr,
    output imem_gnt, imem_rvalid, imem_rdata, id_ready
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding imem handshake
// and fills the IF/ID register. Optional counters enabled by IF_PERF_CNT_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      npc,
  input  logic             redirect,
  input  logic             stall,
  output logic [31:0]      pc_out,
  output logic             fetch_hold,
  if_fetch_stage_if.master bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_killed
`endif
);

  localparam logic [0:0] S_REQ  = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]  state;
  logic [31:0] pc_q;
  logic [31:0] req_pc;
  logic        kill;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  logic        slot_free;
  logic        req;
  logic        grant;
  logic        resp;
  logic        drop;
  logic        load;

  assign slot_free  = ~id_valid | bus.id_ready;
  assign req        = (state == S_REQ) & ~stall & slot_free & ~rst;
  assign grant      = req & bus.imem_gnt;
  // A response only counts while waiting; strays after reset or kill fall through.
  assign resp       = (state == S_WAIT) & bus.imem_rvalid;
  assign drop       = resp & (kill | redirect);
  assign load       = resp & ~kill & ~redirect;

  assign fetch_hold      = ~grant;
  assign pc_out          = pc_q;
  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc_q;
  assign bus.if_id_valid = id_valid;
  assign bus.if_id_pc    = id_pc;
  assign bus.if_id_instr = id_instr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_REQ;
      pc_q   <= RESET_PC;
      kill   <= 1'b0;
      req_pc <= 32'h0;
    end else begin
      if (grant | redirect) pc_q <= npc;
      case (state)
        S_REQ: begin
          if (grant) begin
            req_pc <= pc_q;
            kill   <= redirect;
            state  <= S_WAIT;
          end
        end
        default: begin
          if (bus.imem_rvalid) begin
            kill  <= 1'b0;
            state <= S_REQ;
          end else if (redirect) begin
            kill  <= 1'b1;
          end
        end
      endcase
    end
  end

  // IF/ID register: flush beats load beats consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_pc    <= 32'h0;
      id_instr <= NOP_INSTR;
    end else if (redirect) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
    end else if (load) begin
      id_valid <= 1'b1;
      id_pc    <= req_pc;
      id_instr <= bus.imem_rdata;
    end else if (bus.id_ready & id_valid) begin
      id_valid <= 1'b0;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= 32'h0;
      perf_killed  <= 32'h0;
    end else begin
      if (load) perf_fetched <= perf_fetched + 32'd1;
      if (drop) perf_killed  <= perf_killed + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios then randomized traffic, all
// checked against a transaction-level model of the fetch stage.
module tb_if_fetch_stage;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] npc;
  logic        redirect;
  logic        stall;
  logic [31:0] pc_out;
  logic        fetch_hold;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_killed;
`endif

  if_fetch_stage_if bus ();

  if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk        (clk),
    .rst        (rst),
    .npc        (npc),
    .redirect   (redirect),
    .stall      (stall),
    .pc_out     (pc_out),
    .fetch_hold (fetch_hold),
    .bus        (bus)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_killed  (perf_killed)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural PC, the list of outstanding fetches
  // (address plus whether it has been doomed), and the decode slot.
  logic [31:0] m_pc;
  logic [31:0] pend_pc[$];
  logic        pend_dead[$];
  logic        m_valid;
  logic [31:0] m_ifpc;
  logic [31:0] m_instr;
  logic [31:0] m_fetched;
  logic [31:0] m_killed;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc      = RESET_PC;
    pend_pc   = {};
    pend_dead = {};
    m_valid   = 1'b0;
    m_ifpc    = 32'h0;
    m_instr   = NOP_INSTR;
    m_fetched = 32'h0;
    m_killed  = 32'h0;
  endtask

  // One clock: drive inputs after the falling edge, check, advance the model,
  // then return just after the next rising edge.
  task automatic step(input logic r, input logic st, input logic g, input logic rv,
                      input logic [31:0] rd, input logic redir, input logic [31:0] tgt,
                      input logic rdy, input logic garbage);
    logic        exp_req, grant, dead, load;
    logic [31:0] fpc;
    @(negedge clk);
    exp_req = !r && (pend_pc.size() == 0) && !st && (!m_valid || rdy);
    grant   = exp_req && g;
    rst = r; stall = st; redirect = redir;
    bus.imem_gnt = g; bus.imem_rvalid = rv; bus.imem_rdata = rd; bus.id_ready = rdy;
    if (redir)        npc = tgt;
    else if (grant)   npc = m_pc + 32'd4;
    else if (garbage) npc = $urandom;
    else              npc = m_pc;
    #1;
    chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", bus.imem_addr, m_pc);
    chk("fetch_hold", 32'(fetch_hold), 32'(!grant));
    chk("pc_out", pc_out, m_pc);
    chk("if_id_valid", 32'(bus.if_id_valid), 32'(m_valid));
    if (m_valid) begin
      chk("if_id_pc", bus.if_id_pc, m_ifpc);
      chk("if_id_instr", bus.if_id_instr, m_instr);
    end
`ifdef IF_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_killed", perf_killed, m_killed);
`endif
    if (r) begin
      model_reset();
    end else begin
      load = 1'b0;
      fpc  = 32'h0;
      if (pend_pc.size() != 0 && rv) begin
        dead = pend_dead.pop_front() || redir;
        fpc  = pend_pc.pop_front();
        if (dead) m_killed++;
        else begin
          load = 1'b1;
          m_fetched++;
        end
      end else if (pend_pc.size() != 0 && redir) begin
        pend_dead[0] = 1'b1;
      end
      if (grant) begin
        pend_pc.push_back(m_pc);
        pend_dead.push_back(redir);
      end
      if (redir) begin
        m_valid = 1'b0;
        m_instr = NOP_INSTR;
      end else if (load) begin
        m_valid = 1'b1;
        m_ifpc  = fpc;
        m_instr = rd;
      end else if (rdy) begin
        m_valid = 1'b0;
      end
      if (grant || redir) m_pc = npc;
    end
    @(posedge clk);
    #1;
  endtask

  // Plain fetch: grant cycle followed by its response.
  task automatic fetch_one(input logic [31:0] word);
    step(0, 0, 1, 0, 32'h0, 0, 32'h0, 1, 0);
    step(0, 0, 1, 1, word, 0, 32'h0, 1, 0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; npc = 32'h0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0; bus.id_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_pc", pc_out, RESET_PC);
    chk("rst_valid", 32'(bus.if_id_valid), 32'h0);
    chk("rst_if_pc", bus.if_id_pc, 32'h0);
    chk("rst_instr", bus.if_id_instr, NOP_INSTR);
    chk("rst_req", 32'(bus.imem_req), 32'h0);

    // Back-to-back stream: one instruction every two cycles, in PC order.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 32'h0, 0, 32'h0, 1, 0);
      step(0, 0, 1, 1, 32'h1000_0000 + 32'(i), 0, 32'h0, 1, 0);
      chk("t1_valid", 32'(bus.if_id_valid), 32'h1);
      chk("t1_pc", bus.if_id_pc, 32'(4 * i));
      chk("t1_instr", bus.if_id_instr, 32'h1000_0000 + 32'(i));
    end
    fetch_one(32'h2000_000c);

    // Grant withheld at 0x10.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 0);
    chk("t2_pc_held", pc_out, 32'h10);
    step(0, 0, 1, 0, 32'h0, 0, 32'h0, 1, 0);
    chk("t2_pc_adv", pc_out, 32'h14);
    step(0, 0, 0, 1, 32'h2000_0010, 0, 32'h0, 1, 0);
    for (int i = 0; i < 3; i++) fetch_one(32'h3000_0000 + 32'(i));

    // Redirect while waiting on 0x20; its response must be dropped.
    chk("t3_pc", pc_out, 32'h20);
    step(0, 0, 1, 0, 32'h0, 0, 32'h0, 1, 0);
    step(0, 0, 0, 0, 32'h0, 1, 32'h100, 1, 0);
    step(0, 0, 0, 1, 32'hDEADBEEF, 0, 32'h0, 1, 0);
    chk("t3_valid", 32'(bus.if_id_valid), 32'h0);
    chk("t3_next_addr", bus.imem_addr, 32'h100);
`ifdef IF_PERF_CNT_EN
    chk("t3_killed", perf_killed, 32'h1);
`endif

    // Decode back-pressure holds IF/ID and blocks new requests.
    fetch_one(32'h4000_0100);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 0);
    chk("t4_hold_pc", bus.if_id_pc, 32'h100);
    chk("t4_hold_instr", bus.if_id_instr, 32'h4000_0100);
    chk("t4_pc_held", pc_out, 32'h104);
    step(0, 0, 1, 0, 32'h0, 0, 32'h0, 1, 0);
    chk("t4_issued", pc_out, 32'h108);
    step(0, 0, 0, 1, 32'h4000_0104, 0, 32'h0, 1, 0);

    // Redirect coinciding with a grant at 0x40.
    step(0, 0, 0, 0, 32'h0, 1, 32'h40, 1, 0);
    step(0, 0, 1, 0, 32'h0, 1, 32'h200, 1, 0);
    chk("t5_pc", pc_out, 32'h200);
    step(0, 0, 0, 1, 32'h5000_0040, 0, 32'h0, 1, 0);
    chk("t5_valid", 32'(bus.if_id_valid), 32'h0);
    chk("t5_next_addr", bus.imem_addr, 32'h200);

    // Reset while waiting, then a late response.
    fetch_one(32'h6000_0200);
    step(0, 0, 1, 0, 32'h0, 0, 32'h0, 1, 0);
    step(1, 0, 0, 0, 32'h0, 0, 32'h0, 1, 0);
    step(0, 0, 0, 1, 32'h7777_7777, 0, 32'h0, 1, 0);
    chk("t6_pc", pc_out, RESET_PC);
    chk("t6_valid", 32'(bus.if_id_valid), 32'h0);
    chk("t6_instr", bus.if_id_instr, NOP_INSTR);

    // Randomized traffic including stray responses and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic r, st, g, rv, rdr, rdy;
      r   = ($urandom_range(0, 99) == 0);
      st  = ($urandom_range(0, 99) < 20);
      g   = ($urandom_range(0, 99) < 60);
      rdr = ($urandom_range(0, 99) < 12);
      rdy = ($urandom_range(0, 99) < 60);
      rv  = (pend_pc.size() != 0) ? ($urandom_range(0, 99) < 50)
                                  : ($urandom_range(0, 99) < 10);
      step(r, st, g, rv, $urandom, rdr, $urandom, rdy, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the next-PC logic and feeds the decode stage.
- Owns the architectural PC register and drives `pc_out` and `fetch_hold` into the next-PC block, which computes `npc`.
- Runs a single-outstanding request/grant/response handshake to instruction memory.
- Captures each returned instruction into the IF/ID register with a valid/ready handshake; redirects flush and kill wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word held in `if_id_instr` when the slot is empty or flushed.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- npc  in  32  next PC from the next-PC block.
- redirect  in  1  `npc` is a taken branch, jump or jalr target; flush and kill.
- stall  in  1  hazard-unit hold; no new fetch request this cycle.
- pc_out  out  32  current fetch PC (`pc_q`).
- fetch_hold  out  1  PC not advancing this cycle; next-PC block returns PC instead of PC+4.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address; equals `pc_q`.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  32  instruction word.
- if_id_valid  out  1  IF/ID holds a valid instruction.
- if_id_pc  out  32  PC of the held instruction.
- if_id_instr  out  32  held instruction.
- id_ready  in  1  decode consumes IF/ID this cycle when `if_id_valid` is high.

Behaviour:
- Reset values:
  - state = S_REQ, `pc_q` = RESET_PC, `kill` = 0, `req_pc` = 0.
  - `if_id_valid` = 0, `if_id_pc` = 0, `if_id_instr` = NOP_INSTR.
  - `imem_req` is combinationally 0 during the reset cycle.
- `slot_free` = ~`if_id_valid` | `id_ready`.
- `grant` = `imem_req` & `imem_gnt`.
- `imem_req` = (state == S_REQ) & ~`stall` & `slot_free` & ~`rst`.
- `fetch_hold` = ~`grant`.
- PC update: `pc_q` <= `npc` when `grant` | `redirect`; otherwise `pc_q` holds.
- S_REQ:
  - On `grant`: `req_pc` <= `pc_q`; `kill` <= `redirect`; go to S_WAIT.
  - No `grant`: stay in S_REQ; a redirect only updates `pc_q`.
- S_WAIT:
  - `imem_req` = 0; wait for `imem_rvalid`.
  - `redirect` without `imem_rvalid`: `kill` <= 1.
  - On `imem_rvalid`, the response is discarded when `kill` | `redirect`. Otherwise load IF/ID: valid = 1, pc = `req_pc`, instr = `imem_rdata`. Then `kill` <= 0 and go to S_REQ.
- Only one request is outstanding at a time. The slot is guaranteed free at response time because issue requires `slot_free`.
- `imem_rvalid` in S_REQ is ignored. This covers stale responses after reset or after a kill.
- IF/ID register:
  - `redirect` has highest priority: valid = 0, instr = NOP_INSTR, in the same edge.
  - Otherwise a response load sets valid.
  - Otherwise `id_ready` & valid clears valid.
  - Otherwise hold.
- `stall`:
  - Suppresses new requests only.
  - An in-flight response still completes and loads IF/ID.
  - IF/ID is not flushed by `stall`.
- Simultaneous `redirect` and `grant` in S_REQ: `pc_q` <= `npc` (the redirect target). The granted request is killed.
- Reset mid-transaction: the FSM returns to S_REQ and a late `imem_rvalid` is dropped.
- Arithmetic: no adders in this block. `npc` is trusted; bits [1:0] are passed unchanged.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - Adds outputs `perf_fetched` (32) and `perf_killed` (32), both reset to 0 and wrapping at 2^32.
  - `perf_fetched` increments on each IF/ID load.
  - `perf_killed` increments on each discarded response.
- Undefined: neither the ports nor the counters exist, and all other behaviour is identical.

Test Plan:
1. Reset, then `imem_gnt`=1 always, `imem_rvalid` one cycle after grant, `id_ready`=1, `npc`=`pc_out`+4 → IF/ID presents pc 0x0,0x4,0x8 in order, one instruction every 2 cycles, `fetch_hold`=0 on grant cycles.
2. `imem_gnt` held 0 for 3 cycles at PC 0x10 → `imem_req`=1 and `fetch_hold`=1 throughout, `pc_out` stays 0x10; granted on the 4th cycle → `pc_out`=0x14 next cycle.
3. In S_WAIT for PC 0x20, `redirect`=1 with `npc`=0x100, then `imem_rvalid` with 0xDEADBEEF → response dropped, `if_id_valid`=0, next request `imem_addr`=0x100 (`perf_killed`=1 when IF_PERF_CNT_EN).
4. `if_id_valid`=1 with `id_ready`=0 for 4 cycles → `imem_req`=0, IF/ID contents unchanged; `id_ready`=1 → request issued that cycle.
5. `redirect` and `imem_gnt` in the same S_REQ cycle (`pc_q`=0x40, `npc`=0x200) → response for 0x40 discarded, next request to 0x200.
6. `rst` asserted while in S_WAIT, then `imem_rvalid`=1 → ignored; `pc_out`=RESET_PC, `if_id_valid`=0, `if_id_instr`=0x00000013.
